// File: rtl/vx_warp_ctl_arbiter.sv
// Round-robin arbiter sharing the single warp-control channel among NUM_REQS requesters,
// feeding a one-entry registered valid/ready output stage with op-kind decode and perf counters.
module vx_warp_ctl_arbiter #(
    parameter  int unsigned NUM_REQS       = 4,
    parameter  int unsigned WARP_CNT_WIDTH = 4,
    parameter  int unsigned DATA_WIDTH     = 64,
    parameter  int unsigned PERF_WIDTH     = 32,
    localparam int unsigned SRC_W          = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_REQS-1:0]                 req_valid,
    output logic [NUM_REQS-1:0]                 req_ready,
    input  logic [NUM_REQS*WARP_CNT_WIDTH-1:0]  req_wid,
    input  logic [NUM_REQS*3-1:0]               req_op,
    input  logic [NUM_REQS*DATA_WIDTH-1:0]      req_data,
    output logic                                ctl_valid,
    input  logic                                ctl_ready,
    output logic [WARP_CNT_WIDTH-1:0]           ctl_wid,
    output logic [4:0]                          ctl_kind,
    output logic [DATA_WIDTH-1:0]               ctl_data,
    output logic [SRC_W-1:0]                    ctl_src,
    output logic                                err_illegal_op,
    output logic [PERF_WIDTH-1:0]               perf_grants,
    output logic [PERF_WIDTH-1:0]               perf_stalls
);

    localparam logic [2:0] OP_TMC    = 3'd0;
    localparam logic [2:0] OP_WSPAWN = 3'd1;
    localparam logic [2:0] OP_SPLIT  = 3'd2;
    localparam logic [2:0] OP_JOIN   = 3'd3;
    localparam logic [2:0] OP_BAR    = 3'd4;

    logic                      stage_rdy;
    logic                      grant_vld;
    logic [SRC_W-1:0]          grant_idx;
    logic [SRC_W-1:0]          cand_idx;
    logic [SRC_W-1:0]          ptr;
    logic [SRC_W-1:0]          ptr_next;
    logic [2:0]                grant_op;
    logic [WARP_CNT_WIDTH-1:0] grant_wid;
    logic [DATA_WIDTH-1:0]     grant_data;
    logic [4:0]                kind_dec;
    logic                      illegal_dec;

    assign stage_rdy = !ctl_valid || ctl_ready;

    // Search ptr, ptr+1, ... for the first valid requester; nobody is granted during reset.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand_idx  = '0;
        for (int unsigned k = 0; k < NUM_REQS; k++) begin
            cand_idx = SRC_W'((32'(ptr) + k) % NUM_REQS);
            if (!grant_vld && req_valid[cand_idx]) begin
                grant_vld = 1'b1;
                grant_idx = cand_idx;
            end
        end
        grant_vld = grant_vld && stage_rdy && reset;
    end

    assign req_ready  = grant_vld ? (NUM_REQS'(1) << grant_idx) : '0;
    assign grant_op   = req_op[32'(grant_idx) * 3 +: 3];
    assign grant_wid  = req_wid[32'(grant_idx) * WARP_CNT_WIDTH +: WARP_CNT_WIDTH];
    assign grant_data = req_data[32'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
    assign ptr_next   = (32'(grant_idx) == NUM_REQS - 1) ? '0 : grant_idx + SRC_W'(1);

    // One-hot kind {bar,join,split,wspawn,tmc}; codes 5-7 decode to no kind.
    always_comb begin
        kind_dec    = 5'b00000;
        illegal_dec = 1'b0;
        case (grant_op)
            OP_TMC:    kind_dec = 5'b00001;
            OP_WSPAWN: kind_dec = 5'b00010;
            OP_SPLIT:  kind_dec = 5'b00100;
            OP_JOIN:   kind_dec = 5'b01000;
            OP_BAR:    kind_dec = 5'b10000;
            default:   illegal_dec = 1'b1;
        endcase
    end

    // Output stage: a grant loads over a draining op in the same edge, so there is no bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctl_valid      <= 1'b0;
            ctl_wid        <= '0;
            ctl_kind       <= '0;
            ctl_data       <= '0;
            ctl_src        <= '0;
            ptr            <= '0;
            err_illegal_op <= 1'b0;
        end else if (grant_vld) begin
            ctl_valid <= 1'b1;
            ctl_wid   <= grant_wid;
            ctl_kind  <= kind_dec;
            ctl_data  <= grant_data;
            ctl_src   <= grant_idx;
            ptr       <= ptr_next;
            if (illegal_dec) begin
                err_illegal_op <= 1'b1;
            end
        end else if (ctl_ready) begin
            ctl_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_grants <= '0;
            perf_stalls <= '0;
        end else begin
            if (grant_vld) begin
                perf_grants <= perf_grants + PERF_WIDTH'(1);
            end
            if (ctl_valid && !ctl_ready) begin
                perf_stalls <= perf_stalls + PERF_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_vx_warp_ctl_arbiter.sv
// Bench for vx_warp_ctl_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level reference model of the round-robin channel.
module tb_vx_warp_ctl_arbiter;

    localparam int N  = 4;
    localparam int WW = 4;
    localparam int DW = 64;
    localparam int PW = 32;
    localparam int SW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*WW-1:0]   req_wid;
    logic [N*3-1:0]    req_op;
    logic [N*DW-1:0]   req_data;
    logic              ctl_valid;
    logic              ctl_ready;
    logic [WW-1:0]     ctl_wid;
    logic [4:0]        ctl_kind;
    logic [DW-1:0]     ctl_data;
    logic [SW-1:0]     ctl_src;
    logic              err_illegal_op;
    logic [PW-1:0]     perf_grants;
    logic [PW-1:0]     perf_stalls;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state
    int          m_ptr;
    bit          m_valid;
    logic [3:0]  m_wid;
    logic [4:0]  m_kind;
    logic [63:0] m_data;
    int          m_src;
    bit          m_err;
    logic [31:0] m_grants;
    logic [31:0] m_stalls;

    vx_warp_ctl_arbiter #(
        .NUM_REQS(N), .WARP_CNT_WIDTH(WW), .DATA_WIDTH(DW), .PERF_WIDTH(PW)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_wid(req_wid), .req_op(req_op), .req_data(req_data),
        .ctl_valid(ctl_valid), .ctl_ready(ctl_ready),
        .ctl_wid(ctl_wid), .ctl_kind(ctl_kind), .ctl_data(ctl_data), .ctl_src(ctl_src),
        .err_illegal_op(err_illegal_op),
        .perf_grants(perf_grants), .perf_stalls(perf_stalls)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] kind_of(input logic [2:0] op);
        if (op < 3'd5) return 5'b00001 << op;
        return 5'b00000;
    endfunction

    // Next grant under the rules: stage must be free, first valid from ptr onward.
    function automatic int model_grant();
        logic [1:0] idx;
        if (m_valid && !ctl_ready) return -1;
        for (int k = 0; k < N; k++) begin
            idx = 2'((m_ptr + k) % N);
            if (req_valid[idx]) return int'(idx);
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready();
        int g;
        g = model_grant();
        if (g < 0) return 4'b0000;
        return 4'b0001 << g;
    endfunction

    function automatic logic [140:0] dut_vec();
        return {ctl_valid, ctl_valid ? {ctl_wid, ctl_kind, ctl_data, ctl_src} : 75'b0,
                err_illegal_op, perf_grants, perf_stalls};
    endfunction

    function automatic logic [140:0] mdl_vec();
        return {m_valid, m_valid ? {m_wid, m_kind, m_data, 2'(m_src)} : 75'b0,
                m_err, m_grants, m_stalls};
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_valid = 0; m_wid = '0; m_kind = '0; m_data = '0;
        m_src = 0; m_err = 0; m_grants = '0; m_stalls = '0;
    endtask

    task automatic clear_inputs();
        req_valid = '0; req_wid = '0; req_op = '0; req_data = '0; ctl_ready = 1'b1;
    endtask

    task automatic set_req(input int i, input logic [3:0] w, input logic [2:0] op,
                           input logic [63:0] d);
        req_wid[i*WW +: WW] = w;
        req_op[i*3 +: 3]    = op;
        req_data[i*DW +: DW] = d;
    endtask

    // Advance one clock; the model applies output drain, then any grant seen before the edge.
    task automatic tick(output int g);
        g = model_grant();
        @(posedge clk);
        if (m_valid && !ctl_ready) m_stalls = m_stalls + 32'd1;
        if (m_valid && ctl_ready) m_valid = 0;
        if (g >= 0) begin
            m_valid  = 1;
            m_wid    = req_wid[g*WW +: WW];
            m_kind   = kind_of(req_op[g*3 +: 3]);
            m_data   = req_data[g*DW +: DW];
            m_src    = g;
            if (req_op[g*3 +: 3] >= 3'd5) m_err = 1;
            m_grants = m_grants + 32'd1;
            m_ptr    = (g + 1) % N;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        int g;
        reset = 1'b0;
        clear_inputs();
        req_valid = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({ctl_valid, ctl_wid, ctl_kind, ctl_data, ctl_src, err_illegal_op, perf_grants, perf_stalls} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", {ctl_valid, ctl_wid, ctl_kind, ctl_data, ctl_src, err_illegal_op, perf_grants, perf_stalls});
        end
        n_cmp++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_no_ready: got %b want 0000", req_ready);
        end
        clear_inputs();
        reset = 1'b1;
        model_reset();
        req_valid = 4'b0001;
        set_req(0, 4'd3, 3'd0, 64'h1234_5678_9abc_def0);
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL first_ready: got %b want 0001", req_ready);
        end
        tick(g);
        req_valid = '0;
        n_cmp++;
        if ({ctl_valid, ctl_kind, ctl_wid, ctl_src} !== {1'b1, 5'b00001, 4'd3, 2'd0}) begin
            n_fail++;
            $display("FAIL first_op: got v=%b k=%b w=%0d s=%0d want v=1 k=00001 w=3 s=0",
                     ctl_valid, ctl_kind, ctl_wid, ctl_src);
        end
    endtask

    task automatic test_round_robin();
        int g;
        do_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < N; i++)
            set_req(i, 4'(i + 8), 3'(i), {32'hC0DE_0000, 32'(i)});
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++;
            if (req_ready !== (4'b0001 << (c % N))) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got %b want %b", c, req_ready, 4'b0001 << (c % N));
            end
            tick(g);
            n_cmp++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++;
                $display("FAIL rr_state[%0d]: got %h want %h", c, dut_vec(), mdl_vec());
            end
        end
        n_cmp++;
        if (perf_grants !== 32'd5) begin
            n_fail++;
            $display("FAIL rr_perf_grants: got %0d want 5", perf_grants);
        end
        req_valid = '0;
    endtask

    task automatic test_stall();
        int g;
        logic [74:0] held;
        do_reset();
        req_valid = 4'b0001;
        set_req(0, 4'd5, 3'd2, 64'hAAAA_BBBB_CCCC_DDDD);
        set_req(1, 4'd6, 3'd4, 64'h1111_2222_3333_4444);
        tick(g);
        held = {ctl_wid, ctl_kind, ctl_data, ctl_src};
        ctl_ready = 1'b0;
        req_valid = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if (req_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL stall_ready[%0d]: got %b want 0000", c, req_ready);
            end
            tick(g);
            n_cmp++;
            if ({ctl_valid, ctl_wid, ctl_kind, ctl_data, ctl_src} !== {1'b1, held}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got %h want %h", c,
                         {ctl_valid, ctl_wid, ctl_kind, ctl_data, ctl_src}, {1'b1, held});
            end
        end
        n_cmp++;
        if (perf_stalls !== 32'd3) begin
            n_fail++;
            $display("FAIL stall_count: got %0d want 3", perf_stalls);
        end
        ctl_ready = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL drain_grant_ready: got %b want 0010", req_ready);
        end
        tick(g);
        req_valid = '0;
        n_cmp++;
        if ({ctl_valid, ctl_src, ctl_wid, ctl_kind, perf_grants} !== {1'b1, 2'd1, 4'd6, 5'b10000, 32'd2}) begin
            n_fail++;
            $display("FAIL drain_grant_op: got v=%b s=%0d w=%0d k=%b g=%0d want v=1 s=1 w=6 k=10000 g=2",
                     ctl_valid, ctl_src, ctl_wid, ctl_kind, perf_grants);
        end
    endtask

    task automatic test_wrap();
        int g;
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 4'(i), 3'd1, 64'(i));
        req_valid = 4'b0100;
        tick(g);
        req_valid = 4'b1001;
        #1;
        n_cmp++;
        if (req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL wrap_first: got %b want 1000", req_ready);
        end
        tick(g);
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL wrap_second: got %b want 0001", req_ready);
        end
        tick(g);
        req_valid = '0;
        n_cmp++;
        if ({ctl_valid, ctl_src} !== {1'b1, 2'd0}) begin
            n_fail++;
            $display("FAIL wrap_src: got v=%b s=%0d want v=1 s=0", ctl_valid, ctl_src);
        end
    endtask

    task automatic test_illegal();
        int g;
        do_reset();
        req_valid = 4'b0001;
        set_req(0, 4'd2, 3'd6, 64'hDEAD_BEEF_0000_0001);
        tick(g);
        n_cmp++;
        if ({ctl_valid, ctl_kind, err_illegal_op} !== {1'b1, 5'b00000, 1'b1}) begin
            n_fail++;
            $display("FAIL illegal_op: got v=%b k=%b e=%b want v=1 k=00000 e=1",
                     ctl_valid, ctl_kind, err_illegal_op);
        end
        req_valid = 4'b0010;
        set_req(1, 4'd7, 3'd1, 64'h55);
        for (int c = 0; c < 3; c++) begin
            tick(g);
            n_cmp++;
            if ({ctl_kind, err_illegal_op} !== {5'b00010, 1'b1}) begin
                n_fail++;
                $display("FAIL illegal_sticky[%0d]: got k=%b e=%b want k=00010 e=1",
                         c, ctl_kind, err_illegal_op);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_random();
        int g;
        bit hold [N];
        do_reset();
        for (int i = 0; i < N; i++) hold[i] = 0;
        for (int c = 0; c < 400; c++) begin
            ctl_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < N; i++) begin
                if (!hold[i]) begin
                    req_valid[i] = ($urandom_range(0, 1) == 1);
                    set_req(i, 4'($urandom),
                            ($urandom_range(0, 19) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4)),
                            {$urandom, $urandom});
                end
            end
            #1;
            n_cmp++;
            if (req_ready !== exp_ready()) begin
                n_fail++;
                $display("FAIL rand_ready[%0d]: got %b want %b", c, req_ready, exp_ready());
            end
            tick(g);
            for (int i = 0; i < N; i++) hold[i] = req_valid[i] && (g != i);
            n_cmp++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++;
                $display("FAIL rand_state[%0d]: got %h want %h", c, dut_vec(), mdl_vec());
            end
        end
        req_valid = '0;
    endtask

    task automatic test_async_reset();
        int g;
        do_reset();
        req_valid = 4'b0001;
        set_req(0, 4'd9, 3'd3, 64'h77);
        tick(g);
        ctl_ready = 1'b0;
        req_valid = '0;
        tick(g);
        #2;
        reset = 1'b0;
        req_valid = 4'b1111;
        #1;
        n_cmp++;
        if ({ctl_valid, err_illegal_op, perf_grants, perf_stalls} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b e=%b g=%0d s=%0d want all 0",
                     ctl_valid, err_illegal_op, perf_grants, perf_stalls);
        end
        n_cmp++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_reset_ready: got %b want 0000", req_ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        ctl_ready = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL async_reset_ptr: got %b want 0001", req_ready);
        end
        tick(g);
        req_valid = '0;
        n_cmp++;
        if (dut_vec() !== mdl_vec()) begin
            n_fail++;
            $display("FAIL async_reset_after: got %h want %h", dut_vec(), mdl_vec());
        end
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        model_reset();
        test_reset();
        test_round_robin();
        test_stall();
        test_wrap();
        test_illegal();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
